// File: rtl/dmem_responder.sv
// Single-port data-memory responder: valid/ready request and response channels,
// RISC-V byte/half/word loads and stores, and a fixed response latency.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_CYCLES = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        lat_wr;
  logic [2:0]  lat_ctrl;
  logic [31:0] lat_addr;

  logic        cur_wr;
  logic [2:0]  cur_ctrl;
  logic [31:0] cur_addr;
  logic [AW-1:0] cur_idx;
  size_t       cur_size;
  logic        cur_err;

  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        accept;
  logic        enter_resp;
  logic        mem_we;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign accept     = req_ready && req_valid;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // In IDLE the live bus is decoded so LATENCY=1 can respond straight off the
  // accept edge; afterwards the latched copy keeps the request stable.
  assign cur_wr   = (state == IDLE) ? req_wr   : lat_wr;
  assign cur_ctrl = (state == IDLE) ? req_ctrl : lat_ctrl;
  assign cur_addr = (state == IDLE) ? req_addr : lat_addr;
  assign cur_idx  = cur_addr[AW+1:2];

  always_comb begin
    case (cur_ctrl)
      3'b000, 3'b100: cur_size = SZ_BYTE;
      3'b001, 3'b101: cur_size = SZ_HALF;
      3'b010:         cur_size = SZ_WORD;
      default:        cur_size = SZ_BAD;
    endcase
  end

  always_comb begin
    cur_err = 1'b0;
    if (cur_size == SZ_BAD)                           cur_err = 1'b1;
    if (cur_size == SZ_HALF && cur_addr[0])           cur_err = 1'b1;
    if (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00) cur_err = 1'b1;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS))  cur_err = 1'b1;
  end

  // Stores only happen on an accept edge, so the live bus is always the source.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_wdata;
    case (cur_size)
      SZ_BYTE: begin
        wr_be   = 4'b0001 << cur_addr[1:0];
        wr_data = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      SZ_WORD: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  assign mem_we = accept && req_wr && !cur_err;

  // NOTE: the storage array deliberately has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[cur_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_word  = cur_err ? 32'h0 : mem[cur_idx];
  assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (cur_size)
      SZ_BYTE: ld_data = cur_ctrl[2] ? {24'h0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: ld_data = cur_ctrl[2] ? {16'h0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
      SZ_WORD: ld_data = rd_word;
      default: ld_data = 32'h0;
    endcase
    if (cur_err || cur_wr) ld_data = 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no branch can leave a latch behind.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY <= 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_CYCLES;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_wr    <= 1'b0;
      lat_ctrl  <= 3'b000;
      lat_addr  <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_wr   <= req_wr;
        lat_ctrl <= req_ctrl;
        lat_addr <= req_addr;
      end
      if (enter_resp) begin
        rsp_err   <= cur_err;
        rsp_rdata <= ld_data;
      end else if (rsp_valid && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'h0;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from the request-accept edge to rsp_valid; legal range is 1..15.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock, all state on the rising edge; rst  in  1  asynchronous active-high reset.
REQ-004 The block SHALL have req_valid  in  1  the initiator presents a request.
REQ-005 The block SHALL have req_ready  out  1  the responder can accept a request.
REQ-006 The block SHALL have req_wr  in  1  store when 1, load when 0.
REQ-007 The block SHALL have req_ctrl  in  3  access type, RISC-V funct3 encoding: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-008 The block SHALL have req_addr  in  32  byte address.
REQ-009 The block SHALL have req_wdata  in  32  store data, right-aligned.
REQ-010 The block SHALL have rsp_valid  out  1  a response is pending.
REQ-011 The block SHALL have rsp_ready  in  1  the initiator takes the response.
REQ-012 The block SHALL have rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-013 The block SHALL have rsp_err  out  1  the request was rejected.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-015 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; all request fields SHALL be latched on that edge.
REQ-016 rsp_valid SHALL rise exactly LATENCY cycles after the accept edge: LATENCY=1 goes IDLE->RESP, LATENCY>1 goes IDLE->WAIT and counts down LATENCY-1 cycles, then goes to RESP.
REQ-017 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1; that edge returns the FSM to IDLE.
REQ-018 A new request SHALL NOT be accepted in the response-handshake cycle; the minimum request spacing is LATENCY+1 cycles.
REQ-019 Word index = addr[31:2]; a request SHALL be an error if the word index >= DEPTH_WORDS.
REQ-020 A request SHALL be an error if the half access has addr[0]=1.
REQ-021 A request SHALL be an error if the word access has addr[1:0]!=0.
REQ-022 A request SHALL be an error if req_ctrl is 011, 110 or 111.
REQ-023 An error request SHALL NOT modify memory, and it SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-024 A store SHALL commit on the accept edge, using byte lanes selected by addr[1:0]: byte writes req_wdata[7:0] to lane addr[1:0]; half writes req_wdata[15:0] to lanes {addr[1],0}+1..0; word writes all lanes; other lanes SHALL be unchanged.
REQ-025 A load SHALL capture data from memory on the edge entering RESP, so a load issued after a store sees the stored value.
REQ-026 Byte and half loads SHALL be sign-extended for codes 000/001 and zero-extended for codes 100/101.
REQ-027 req_valid in states other than IDLE SHALL be ignored, with no side effect.

Reset
REQ-028 When rst asserts, the FSM SHALL go to IDLE immediately (asynchronously), with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the latency counter at 0.
REQ-029 If rst asserts mid-transaction, the pending response SHALL be dropped; a store already committed on its accept edge SHALL remain in memory.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 The first accept after rst deasserts SHALL be possible on the first rising edge with rst=0.

Verification
REQ-032 The bench SHALL cover: with LATENCY=2, store word 0xDEADBEEF to address 0x10, then load word from 0x10 -> rsp_valid 2 cycles after each accept, load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 The bench SHALL cover: store byte 0x80 to 0x13 over word 0x00000000, then load byte from 0x13 -> 0xFFFFFF80, and load byte unsigned from 0x13 -> 0x00000080; load word from 0x10 -> 0x80000000.
REQ-034 The bench SHALL cover: load half from 0x11 and store word to 0x400 (with DEPTH_WORDS=256) -> rsp_err=1, rsp_rdata=0, and memory unchanged on read-back.
REQ-035 The bench SHALL cover: rsp_ready held low for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0 throughout, and req_valid pulses ignored.
REQ-036 The bench SHALL cover: rst asserted in WAIT after a load accept -> outputs at reset values with no clock edge, and no response after rst deasserts.
REQ-037 The bench SHALL cover: with LATENCY=1, back-to-back requests with rsp_ready=1 tied -> one accept every 2 cycles, rsp_valid for exactly 1 cycle each.
